// File: rtl/branch_jump_ctrl.sv
// Moore control sequencer for the Mini-SRC datapath: instruction fetch plus the
// control-flow and I/O-move group (jr, jal, br, in, out, mfhi, mflo, nop, halt).
module branch_jump_ctrl #(
  parameter int unsigned MEM_WAIT = 0,
  parameter logic [4:0]  ALU_ADD  = 5'b00011
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        Cout,
  output logic        Rout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Rin,
  output logic        R15in,
  output logic        CONin,
  output logic        OutPortin,
  output logic        Gra,
  output logic        Grb,
  output logic        Read,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic        illegal,
  output logic [3:0]  state_o
);

  typedef enum logic [3:0] {
    ST_RST  = 4'b0000,
    ST_T0   = 4'b0111,
    ST_T1   = 4'b1000,
    ST_T2   = 4'b1001,
    ST_T3   = 4'b1010,
    ST_T4   = 4'b1011,
    ST_T5   = 4'b1100,
    ST_T6   = 4'b1101,
    ST_HALT = 4'b1111
  } state_t;

  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t     state;
  logic [3:0] wait_cnt;
  logic [4:0] opcode;

  // Only the opcode field steers this controller; the rest of IR is datapath business.
  logic unused_ir;
  assign unused_ir = ^IR[26:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= ST_RST;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_RST: state <= ST_T0;
        ST_T0:  state <= ST_T1;
        ST_T1: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            state    <= ST_T2;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_T2: begin
          opcode <= IR[31:27];
          state  <= ST_T3;
        end
        ST_T3: begin
          case (opcode)
            OP_JAL, OP_BR: state <= ST_T4;
            OP_HALT:       state <= ST_HALT;
            default:       state <= ST_T0;
          endcase
        end
        ST_T4:   state <= (opcode == OP_BR) ? ST_T5 : ST_T0;
        ST_T5:   state <= ST_T6;
        ST_T6:   state <= ST_T0;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_RST;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    {PCout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, Rout} = '0;
    {PCin, IncPC, MARin, MDRin, IRin, Yin, Zlowin, Rin, R15in, CONin, OutPortin} = '0;
    {Gra, Grb, Read} = '0;
    alu_op  = '0;
    illegal = 1'b0;
    run     = (state != ST_HALT);
    case (state)
      ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1; end
      ST_T1: begin Read = 1'b1; MDRin = 1'b1; end
      ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      ST_T3: begin
        case (opcode)
          OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          OP_JAL:  begin PCout = 1'b1; R15in = 1'b1; end
          OP_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          OP_IN:   begin Gra = 1'b1; Rin = 1'b1; InPortout = 1'b1; end
          OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
          OP_MFHI: begin Gra = 1'b1; Rin = 1'b1; HIout = 1'b1; end
          OP_MFLO: begin Gra = 1'b1; Rin = 1'b1; LOout = 1'b1; end
          OP_NOP, OP_HALT: ;
          default: illegal = 1'b1;
        endcase
      end
      ST_T4: begin
        if (opcode == OP_JAL) begin
          Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
        end else if (opcode == OP_BR) begin
          PCout = 1'b1; Yin = 1'b1;
        end
      end
      ST_T5: begin Cout = 1'b1; alu_op = ALU_ADD; Zlowin = 1'b1; end
      // CON was loaded back in T3, so it is stable by the time the target is written.
      ST_T6: begin Zlowout = 1'b1; PCin = CON; end
      default: ;
    endcase
  end

  assign state_o = state;

endmodule
